// File: rtl/mips_bus_arbiter.sv
// Two-master (fetch/data) arbiter onto one memory bus; optional MIPS_ARB_ROUND_ROBIN_EN alternates conflicting grants.
// Latency: grant one edge after request, strobe the cycle after; read data valid the cycle after acceptance.
// Backpressure: slave waitrequest stalls only the owner; the other master (and both when idle/RDATA) sees waitrequest=1.
module mips_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   i_address,
    input  logic                i_read,
    output logic                i_waitrequest,
    output logic [DATA_W-1:0]   i_readdata,
    output logic                i_readdatavalid,
    input  logic [ADDR_W-1:0]   d_address,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [DATA_W-1:0]   d_writedata,
    input  logic [DATA_W/8-1:0] d_byteenable,
    output logic                d_waitrequest,
    output logic [DATA_W-1:0]   d_readdata,
    output logic                d_readdatavalid,
    output logic [ADDR_W-1:0]   address,
    output logic                read,
    output logic                write,
    output logic [DATA_W-1:0]   writedata,
    output logic [DATA_W/8-1:0] byteenable,
    input  logic                waitrequest,
    input  logic [DATA_W-1:0]   readdata
);

    typedef enum logic [1:0] {IDLE, OWN, RDATA} state_t;

    localparam logic M_I = 1'b0;
    localparam logic M_D = 1'b1;

    state_t state, state_nxt;
    logic   owner, owner_nxt;
    logic   d_req, grant_d;
    logic   own_rd, own_wr;

    assign d_req = d_read | d_write;

`ifdef MIPS_ARB_ROUND_ROBIN_EN
    logic last, last_nxt;

    // On a conflict, hand the bus to whichever master did not get it last time.
    assign grant_d = d_req & (~i_read | (last == M_I));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last <= M_I;
        end else begin
            last <= last_nxt;
        end
    end

    always_comb begin
        last_nxt = last;
        if (state == OWN && (own_rd | own_wr) && !waitrequest) begin
            last_nxt = owner;
        end
    end
`else
    assign grant_d = d_req;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            owner <= M_I;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end

    // Owner strobes; a simultaneous data read+write collapses to the write.
    always_comb begin
        own_rd = 1'b0;
        own_wr = 1'b0;
        if (owner == M_D) begin
            own_wr = d_write;
            own_rd = d_read & ~d_write;
        end else begin
            own_rd = i_read;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        case (state)
            IDLE: begin
                if (i_read | d_req) begin
                    owner_nxt = grant_d ? M_D : M_I;
                    state_nxt = OWN;
                end
            end
            OWN: begin
                if (!(own_rd | own_wr)) begin
                    state_nxt = IDLE;
                end else if (!waitrequest) begin
                    state_nxt = own_wr ? IDLE : RDATA;
                end
            end
            RDATA:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        address         = '0;
        read            = 1'b0;
        write           = 1'b0;
        writedata       = '0;
        byteenable      = '0;
        i_waitrequest   = 1'b1;
        d_waitrequest   = 1'b1;
        i_readdatavalid = 1'b0;
        d_readdatavalid = 1'b0;
        case (state)
            OWN: begin
                read  = own_rd;
                write = own_wr;
                if (owner == M_D) begin
                    address       = d_address;
                    writedata     = d_writedata;
                    byteenable    = d_byteenable;
                    d_waitrequest = waitrequest;
                end else begin
                    address       = i_address;
                    byteenable    = '1;
                    i_waitrequest = waitrequest;
                end
            end
            RDATA: begin
                if (owner == M_D) begin
                    d_readdatavalid = 1'b1;
                end else begin
                    i_readdatavalid = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign i_readdata = readdata;
    assign d_readdata = readdata;

endmodule
